// File: rtl/io_input_handshake.sv
// io_input_handshake: stalls the pipeline on an IN instruction until the user
// confirms with the debounced (active-low) button. On confirmation it captures
// the switch value, zero-extends it to DATA_WIDTH and releases the stall with a
// one-cycle data_valid strobe.
// Optional feature macro: INPUT_TIMEOUT_EN (gives up waiting after
// 2**TIMEOUT_BITS-1 cycles and returns 0 with a sticky timeout flag).
module io_input_handshake #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned SW_WIDTH     = 16,
    parameter int unsigned TIMEOUT_BITS = 26
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_req,
    input  logic [SW_WIDTH-1:0]   sw_in,
    input  logic                  btn_pulse_n,
    output logic                  stall,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  waiting_led,
    output logic                  timeout
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FLUSH     = 3'd1,
        WAIT_LOW  = 3'd2,
        WAIT_HIGH = 3'd3,
        DONE      = 3'd4
    } state_t;

    // Elaboration-time parameter sanity check
    if (DATA_WIDTH < SW_WIDTH || TIMEOUT_BITS < 1) begin : g_param_check
        $error("io_input_handshake: DATA_WIDTH must be >= SW_WIDTH and TIMEOUT_BITS >= 1");
    end

    state_t state;
    state_t next_state;
    logic   waiting_c;
    logic   tmo_hit_c;
    logic   capture_c;
    logic   data_valid_nxt;
    logic   waiting_led_nxt;

    assign waiting_c = (state == FLUSH) || (state == WAIT_LOW);

`ifdef INPUT_TIMEOUT_EN
    logic [TIMEOUT_BITS-1:0] to_cnt;

    // An abort (in_req low) takes priority over an expiring timeout
    assign tmo_hit_c = in_req && waiting_c && (&to_cnt);

    // Wait-cycle counter: runs only while waiting for the user
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt <= '0;
        end else if (waiting_c) begin
            to_cnt <= to_cnt + TIMEOUT_BITS'(1);
        end else begin
            to_cnt <= '0;
        end
    end

    // Sticky timeout flag, cleared when the next transaction starts
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout <= 1'b0;
        end else if (state == IDLE && in_req) begin
            timeout <= 1'b0;
        end else if (tmo_hit_c) begin
            timeout <= 1'b1;
        end
    end
`else
    assign tmo_hit_c = 1'b0;
    assign timeout   = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; a press already low at request time is flushed first
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (in_req) begin
                    next_state = btn_pulse_n ? WAIT_LOW : FLUSH;
                end
            end
            FLUSH: begin
                if (!in_req) begin
                    next_state = IDLE;
                end else if (tmo_hit_c) begin
                    next_state = DONE;
                end else if (btn_pulse_n) begin
                    next_state = WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                if (!in_req) begin
                    next_state = IDLE;
                end else if (tmo_hit_c) begin
                    next_state = DONE;
                end else if (!btn_pulse_n) begin
                    next_state = WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                if (!in_req) begin
                    next_state = IDLE;
                end else if (btn_pulse_n) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Output decode: combinational stall plus next values of registered outputs
    always_comb begin
        stall           = in_req && (state != DONE);
        capture_c       = (state == WAIT_LOW) && in_req && !btn_pulse_n && !tmo_hit_c;
        data_valid_nxt  = (next_state == DONE);
        waiting_led_nxt = (next_state == FLUSH) || (next_state == WAIT_LOW);
    end

    // Registered status outputs, aligned with the state register
    always_ff @(posedge clk) begin
        if (rst) begin
            data_valid  <= 1'b0;
            waiting_led <= 1'b0;
        end else begin
            data_valid  <= data_valid_nxt;
            waiting_led <= waiting_led_nxt;
        end
    end

    // Captured data: holds between transactions, zeroed on timeout
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out <= '0;
        end else if (tmo_hit_c) begin
            data_out <= '0;
        end else if (capture_c) begin
            data_out <= DATA_WIDTH'(sw_in);
        end
    end

endmodule
